// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, load alignment and register-file writeback select
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_link,
    input  logic [2:0]            in_load_type,
    input  logic [1:0]            in_byte_offset,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_rdata,
    input  logic [DATA_W-1:0]     in_pc_plus8,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  write_enable,
    output logic                  load_misalign,
    output logic [31:0]           retired_count
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic                  valid_q;
    logic                  reg_write_q;
    logic                  mem_to_reg_q;
    logic                  link_q;
    logic [2:0]            load_type_q;
    logic [1:0]            byte_offset_q;
    logic [DATA_W-1:0]     alu_result_q;
    logic [DATA_W-1:0]     mem_rdata_q;
    logic [DATA_W-1:0]     pc_plus8_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [31:0]           retired_q;

    // Flush only drops valid; the remaining fields are left as they were.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            link_q        <= 1'b0;
            load_type_q   <= 3'b000;
            byte_offset_q <= 2'b00;
            alu_result_q  <= '0;
            mem_rdata_q   <= '0;
            pc_plus8_q    <= '0;
            write_reg_q   <= '0;
            retired_q     <= 32'd0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q       <= in_valid;
                reg_write_q   <= in_reg_write;
                mem_to_reg_q  <= in_mem_to_reg;
                link_q        <= in_link;
                load_type_q   <= in_load_type;
                byte_offset_q <= in_byte_offset;
                alu_result_q  <= in_alu_result;
                mem_rdata_q   <= in_mem_rdata;
                pc_plus8_q    <= in_pc_plus8;
                write_reg_q   <= in_write_reg;
            end
            if (valid_q && !stall && !flush) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] aligned;
    logic              misaligned;

    always_comb begin
        byte_sel = 8'h00;
        case (byte_offset_q)
            2'd0:    byte_sel = mem_rdata_q[7:0];
            2'd1:    byte_sel = mem_rdata_q[15:8];
            2'd2:    byte_sel = mem_rdata_q[23:16];
            default: byte_sel = mem_rdata_q[31:24];
        endcase
        half_sel = byte_offset_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
    end

    // Unused load-type codes fall through to a full-word load.
    always_comb begin
        aligned    = mem_rdata_q;
        misaligned = 1'b0;
        case (load_type_q)
            LT_LB:  aligned = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LT_LBU: aligned = {{(DATA_W-8){1'b0}}, byte_sel};
            LT_LH: begin
                aligned    = {{(DATA_W-16){half_sel[15]}}, half_sel};
                misaligned = byte_offset_q[0];
            end
            LT_LHU: begin
                aligned    = {{(DATA_W-16){1'b0}}, half_sel};
                misaligned = byte_offset_q[0];
            end
            default: begin
                aligned    = mem_rdata_q;
                misaligned = (byte_offset_q != 2'b00);
            end
        endcase
    end

    assign load_misalign = valid_q & mem_to_reg_q & misaligned;
    assign write_reg     = write_reg_q;
    assign write_data    = link_q ? pc_plus8_q : (mem_to_reg_q ? aligned : alu_result_q);
    assign write_enable  = valid_q & reg_write_q & (write_reg_q != '0) & ~load_misalign;
    assign retired_count = retired_q;

endmodule
